// File: rtl/param_up_down_counter_if.sv
// Control/status bundle for param_up_down_counter.
// The master drives the count controls; the slave (the counter) returns
// the count and its event flags.
interface param_up_down_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             enable;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             unf;
    logic             err_sticky;

    modport master (
        output clr, load, load_val, enable, up_down,
        input  count, tc, ovf, unf, err_sticky
    );

    modport slave (
        input  clr, load, load_val, enable, up_down,
        output count, tc, ovf, unf, err_sticky
    );
endinterface

// File: rtl/param_up_down_counter.sv
// Parameterised up/down counter with a programmable terminal value,
// wrap or saturate behaviour at both ends, one-cycle overflow/underflow
// pulses and a sticky error flag.
// Per-edge priority: clr > load > enable > hold.
module param_up_down_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    param_up_down_counter_if.slave       bus
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             err_q, err_d;
    logic             at_max;
    logic             at_zero;

    // Loaded values above the terminal count are pulled down to it so the
    // count can never leave 0..MAX_VAL.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    // Next-state: priority chain plus boundary handling for each direction.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        err_d   = err_q;
        if (bus.clr) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (bus.load) begin
            count_d = clamp_load(bus.load_val);
        end else if (bus.enable) begin
            if (bus.up_down) begin
                if (at_max) begin
                    ovf_d   = 1'b1;
                    err_d   = 1'b1;
                    count_d = SATURATE ? MAX_VAL : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    unf_d   = 1'b1;
                    err_d   = 1'b1;
                    count_d = SATURATE ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // State registers; reset clears everything immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    // Terminal count looks at the live inputs: it warns that the coming
    // enabled step will cross a boundary, and is masked by clr/load.
    assign bus.tc = bus.enable & ~bus.clr & ~bus.load &
                    ((bus.up_down & at_max) | (~bus.up_down & at_zero));

    assign bus.count      = count_q;
    assign bus.ovf        = ovf_q;
    assign bus.unf        = unf_q;
    assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Bench for param_up_down_counter: three instances (4-bit/MAX 9 wrapping,
// 4-bit/MAX 9 saturating, default 8-bit wrapping) driven by directed
// vectors; expectations go into a queue and a monitor compares them.
module tb_param_up_down_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_no = 0;
    event chk_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_up_down_counter_if #(.WIDTH(4)) if0 ();
    param_up_down_counter_if #(.WIDTH(4)) if1 ();
    param_up_down_counter_if #(.WIDTH(8)) if2 ();

    param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    param_up_down_counter dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct {
        int          cyc;
        int          d;
        bit          is_tc;
        int          vec;
        logic [31:0] exp_cnt;
        logic        exp_ovf;
        logic        exp_unf;
        logic        exp_err;
        logic        exp_tc;
    } exp_t;

    exp_t sb[$];

    task automatic read_out(input int d, output logic [31:0] c, output logic o,
                            output logic u, output logic e, output logic t);
        case (d)
            0:       begin c = 32'(if0.count); o = if0.ovf; u = if0.unf; e = if0.err_sticky; t = if0.tc; end
            1:       begin c = 32'(if1.count); o = if1.ovf; u = if1.unf; e = if1.err_sticky; t = if1.tc; end
            default: begin c = 32'(if2.count); o = if2.ovf; u = if2.unf; e = if2.err_sticky; t = if2.tc; end
        endcase
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] c;
        logic        o, u, er, t;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            read_out(e.d, c, o, u, er, t);
            n_cmp++;
            if (e.is_tc) begin
                if (t !== e.exp_tc) begin
                    n_bad++;
                    $display("FAIL tc dut%0d vec%0d: got %b, want %b", e.d, e.vec, t, e.exp_tc);
                end
            end else if ({c, o, u, er} !== {e.exp_cnt, e.exp_ovf, e.exp_unf, e.exp_err}) begin
                n_bad++;
                $display("FAIL state dut%0d vec%0d: got cnt=%0d ovf=%b unf=%b err=%b, want cnt=%0d ovf=%b unf=%b err=%b",
                         e.d, e.vec, c, o, u, er, e.exp_cnt, e.exp_ovf, e.exp_unf, e.exp_err);
            end
        end
    endtask

    // Monitor: compare on every falling edge, plus on demand between edges.
    always @(negedge clk) drain();
    always @(chk_ev) drain();

    task automatic push(input int d, input bit is_tc, input bit etc,
                        input int ecnt, input bit eo, input bit eu, input bit ee);
        exp_t e;
        e.cyc = cyc; e.d = d; e.is_tc = is_tc; e.vec = vec_no;
        e.exp_cnt = 32'(ecnt); e.exp_ovf = eo; e.exp_unf = eu; e.exp_err = ee; e.exp_tc = etc;
        sb.push_back(e);
    endtask

    task automatic set_in(input int d, input bit c, input bit l, input int lv,
                          input bit en, input bit ud);
        case (d)
            0:       begin if0.clr = c; if0.load = l; if0.load_val = 4'(lv); if0.enable = en; if0.up_down = ud; end
            1:       begin if1.clr = c; if1.load = l; if1.load_val = 4'(lv); if1.enable = en; if1.up_down = ud; end
            default: begin if2.clr = c; if2.load = l; if2.load_val = 8'(lv); if2.enable = en; if2.up_down = ud; end
        endcase
    endtask

    // One edge: apply inputs, expect tc before the edge and state after it.
    task automatic vec(input int d, input bit c, input bit l, input int lv,
                       input bit en, input bit ud, input bit etc,
                       input int ecnt, input bit eo, input bit eu, input bit ee);
        set_in(d, c, l, lv, en, ud);
        push(d, 1'b1, etc, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        push(d, 1'b0, 1'b0, ecnt, eo, eu, ee);
        vec_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Reset state of all three instances.
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            push(d, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            push(d, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        vec_no++;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Wrap-up from 7: 8, 9, 0 (ovf), 1.
        vec(0, 0, 1,  7, 0, 1, 0, 7, 0, 0, 0);
        vec(0, 0, 0,  0, 1, 1, 0, 8, 0, 0, 0);
        vec(0, 0, 0,  0, 1, 1, 0, 9, 0, 0, 0);
        vec(0, 0, 0,  0, 1, 1, 1, 0, 1, 0, 1);
        vec(0, 0, 0,  0, 1, 1, 0, 1, 0, 0, 1);
        vec(0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 1);
        // Clamp: 15 loads as 9, then wrap with ovf.
        vec(0, 0, 1, 15, 0, 1, 0, 9, 0, 0, 1);
        vec(0, 0, 0,  0, 1, 1, 1, 0, 1, 0, 1);
        // Down from 0 wraps to 9 with unf.
        vec(0, 0, 0,  0, 1, 0, 1, 9, 0, 1, 1);
        // clr beats load and enable, and clears the sticky flag.
        vec(0, 1, 1,  5, 1, 1, 0, 0, 0, 0, 0);
        vec(0, 0, 1,  5, 0, 1, 0, 5, 0, 0, 0);
        // Direction change with no dead cycle.
        vec(0, 0, 0,  0, 1, 0, 0, 4, 0, 0, 0);
        vec(0, 0, 0,  0, 1, 1, 0, 5, 0, 0, 0);
        // load beats enable, also at the terminal value.
        vec(0, 0, 1,  9, 1, 0, 0, 9, 0, 0, 0);
        vec(0, 0, 1,  3, 1, 1, 0, 3, 0, 0, 0);
        vec(0, 0, 0,  0, 1, 1, 0, 4, 0, 0, 0);
        vec(0, 0, 0,  0, 1, 1, 0, 5, 0, 0, 0);
        vec(0, 0, 0,  0, 1, 1, 0, 6, 0, 0, 0);

        // Asynchronous reset between edges at count 6.
        #5;
        set_in(0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        rst_n = 1'b0;
        push(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        push(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        -> chk_ev;
        vec_no++;
        @(posedge clk); #1;
        push(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        vec_no++;
        rst_n = 1'b1;
        vec(0, 0, 0,  0, 1, 1, 0, 1, 0, 0, 0);
        vec(0, 0, 0,  0, 1, 1, 0, 2, 0, 0, 0);
        set_in(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Saturating instance: hold at 9 on up, hold at 0 on down.
        vec(1, 0, 1,  9, 0, 1, 0, 9, 0, 0, 0);
        vec(1, 0, 0,  0, 1, 1, 1, 9, 1, 0, 1);
        vec(1, 0, 1,  2, 0, 0, 0, 2, 0, 0, 1);
        vec(1, 0, 0,  0, 1, 0, 0, 1, 0, 0, 1);
        vec(1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1);
        vec(1, 0, 0,  0, 1, 0, 1, 0, 0, 1, 1);
        vec(1, 0, 0,  0, 1, 0, 1, 0, 0, 1, 1);
        vec(1, 0, 0,  0, 1, 1, 0, 1, 0, 0, 1);
        vec(1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1);
        vec(1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        set_in(1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Default 8-bit instance: 254 -> 255 -> 0 -> 1, then hold.
        vec(2, 0, 1, 254, 0, 1, 0, 254, 0, 0, 0);
        vec(2, 0, 0,   0, 1, 1, 0, 255, 0, 0, 0);
        vec(2, 0, 0,   0, 1, 1, 1,   0, 1, 0, 1);
        vec(2, 0, 0,   0, 1, 1, 0,   1, 0, 0, 1);
        vec(2, 0, 0,   0, 0, 1, 0,   1, 0, 0, 1);
        vec(2, 0, 0,   0, 0, 1, 0,   1, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: %0d expectations never compared, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_up_down_counter.md
PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal (highest) count value, legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous clear of count and of the sticky flag.
REQ-007 load  input  1  synchronous parallel load of load_val.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 enable  input  1  count enable.
REQ-010 up_down  input  1  direction: 1 = up, 0 = down.
REQ-011 count  output  WIDTH  registered count value.
REQ-012 tc  output  1  combinational terminal-count flag: the next enabled step crosses a boundary.
REQ-013 ovf  output  1  registered one-cycle pulse: an up-step was attempted at MAX_VAL.
REQ-014 unf  output  1  registered one-cycle pulse: a down-step was attempted at 0.
REQ-015 err_sticky  output  1  registered flag, set by any ovf or unf event and held until clr or reset.

Function
REQ-016 Per-edge priority SHALL be clr > load > enable > hold.
REQ-017 clr: count <= 0, err_sticky <= 0, ovf <= 0, unf <= 0.
REQ-018 load: count <= min(load_val, MAX_VAL); a load_val above MAX_VAL is clamped to MAX_VAL; ovf <= 0, unf <= 0, err_sticky unchanged.
REQ-019 enable=1, up_down=1, count<MAX_VAL: count <= count+1, with no event.
REQ-020 enable=1, up_down=0, count>0: count <= count-1, with no event.
REQ-021 enable=1, up_down=1, count==MAX_VAL: count <= 0 when SATURATE=0 and holds MAX_VAL when SATURATE=1; ovf <= 1 in both modes.
REQ-022 enable=1, up_down=0, count==0: count <= MAX_VAL when SATURATE=0 and holds 0 when SATURATE=1; unf <= 1 in both modes.
REQ-023 ovf and unf SHALL be high only in the cycle following the triggering edge, SHALL never be high together, and SHALL be 0 on every edge without an event.
REQ-024 err_sticky SHALL go high on the same edge that sets ovf or unf, and SHALL stay high through load and hold until clr or reset.
REQ-025 tc = enable & ~clr & ~load & ((up_down & count==MAX_VAL) | (~up_down & count==0)), with no registered delay.
REQ-026 enable=0 with no clr or load: count holds, ovf=unf=0.
REQ-027 up_down SHALL be sampled each edge; a direction change takes effect on the same edge with no dead cycle.
REQ-028 All arithmetic SHALL be WIDTH-bit with explicit boundary compares; count SHALL never take a value above MAX_VAL.
REQ-029 Latency from input to count, ovf, unf and err_sticky SHALL be one clock edge.

Reset
REQ-030 rst_n=0 SHALL force count=0, ovf=0, unf=0 and err_sticky=0 immediately, independent of clk.
REQ-031 Reset asserted mid-count SHALL override all inputs; the first edge after rst_n rises SHALL apply the normal priority starting from count=0.
REQ-032 tc SHALL be 0 during reset only as a result of count=0 with enable low; it follows REQ-025 otherwise.

Verification (WIDTH=4, MAX_VAL=9 unless noted)
REQ-033 Wrap-up: SATURATE=0, load 7, then enable up for 4 edges -> count 8, 9, 0, 1; ovf high for exactly one cycle after the 9->0 edge; tc high while count=9; err_sticky=1 afterwards.
REQ-034 Saturate-down: SATURATE=1, count 2, enable down for 4 edges -> count 1, 0, 0, 0; unf pulses after each of the last two edges; err_sticky stays 1.
REQ-035 Priority: clr=1, load=1 (load_val=5) and enable=1 on the same edge -> count=0, err_sticky=0; next edge with load only -> count=5.
REQ-036 Clamp: load_val=15 -> count=9; one enabled up-step -> count=0 (wrap) and ovf=1.
REQ-037 Async reset: rst_n driven low between edges at count=6 -> count=0 before the next edge; with enable up held, the first edges after release -> count 1, 2.
REQ-038 Default parameters (WIDTH=8): up from 254 for 3 edges -> count 255, 0, 1; hold for 2 edges with enable=0 -> count stays 1, ovf=0.
